spi_packet_master: RTL and testbench

SPI Mode 0 master that reads the 16-byte sensor packet from the FPGA-side packet slave, for on-board loopback and for the second-FPGA receive path. It waits for `done`, clocks 128 bits MSB first, checks the 0xAA header, and unpacks quaternion, gyro and flag fields into registered outputs. It then pulses `load` and waits for `done` to fall before arming again.

---
 rtl/spi_pkt_pkg.sv | 50 +++++
 rtl/spi_sck_gen.sv | 40 ++++
 rtl/spi_packet_master.sv | 195 +++++++++++++++++++
 tb/tb_spi_packet_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkt_pkg.sv
// Shared types and constants for the SPI sensor-packet master.
// Packet layout: header, quaternion w/x/y/z, gyro x/y/z, flags; all fields big-endian.
package spi_pkt_pkg;

  localparam logic [7:0] HEADER_BYTE  = 8'hAA;
  localparam int         PACKET_BYTES = 16;
  localparam int         PACKET_BITS  = 128;

  localparam int OFF_HDR   = 0;
  localparam int OFF_QW    = 1;
  localparam int OFF_QX    = 3;
  localparam int OFF_QY    = 5;
  localparam int OFF_QZ    = 7;
  localparam int OFF_GX    = 9;
  localparam int OFF_GY    = 11;
  localparam int OFF_GZ    = 13;
  localparam int OFF_FLAGS = 15;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_XFER     = 3'd2,
    ST_DECODE   = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_LOW = 3'd5
  } spi_pkt_state_t;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] gx;
    logic [15:0] gy;
    logic [15:0] gz;
    logic [7:0]  flags;
  } sensor_pkt_t;

  // Byte 0 is the first byte on the wire, i.e. the MSB end of the shift register.
  function automatic logic [7:0] pkt_byte(input logic [PACKET_BITS-1:0] sr, input int idx);
    return sr[PACKET_BITS-1-8*idx -: 8];
  endfunction

  function automatic logic [15:0] pkt_field16(input logic [PACKET_BITS-1:0] sr, input int idx);
    return {pkt_byte(sr, idx), pkt_byte(sr, idx + 1)};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: divides clk into an idle-low SCK while enabled and
// flags the clk cycle on which SCK is about to rise or fall.
module spi_sck_gen
  import spi_pkt_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_packet_master.sv
// SPI mode-0 master that reads a 16-byte sensor packet when the slave raises done,
// checks the header, unpacks the fields and acknowledges with a load pulse.
// Build option: SPI_PKT_TIMEOUT_EN bounds the wait for done to fall after load.
//
// state     | meaning
// IDLE      | waiting for done_s
// SETUP     | sck held low CLK_DIV cycles while slave presents bit 127
// XFER      | 128 sck periods, sdi sampled on each rising edge
// DECODE    | header check, field registers updated
// ACK       | load held high LOAD_CYCLES cycles
// WAIT_LOW  | waiting for done_s to drop (optionally bounded by TIMEOUT)
module spi_packet_master
  import spi_pkt_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int LOAD_CYCLES = 8,
  parameter int TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  output logic        load,
  output logic        sck,
  output logic        sdo,
  input  logic        sdi,
  output logic [15:0] quat_w,
  output logic [15:0] quat_x,
  output logic [15:0] quat_y,
  output logic [15:0] quat_z,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        quat_valid,
  output logic        gyro_valid,
  output logic        pkt_valid,
  output logic        hdr_err,
  output logic        timeout_err,
  output logic        busy
);

  spi_pkt_state_t         state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [6:0]             bit_cnt;
  logic [PACKET_BITS-1:0] sr;
  logic                   done_meta, done_s;
  logic                   sck_en, sck_rise, sck_fall;

`ifdef SPI_PKT_TIMEOUT_EN
  logic tmo_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_meta <= 1'b0;
      done_s    <= 1'b0;
    end else begin
      done_meta <= done;
      done_s    <= done_meta;
    end
  end

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk   (clk),
    .reset (reset),
    .en    (sck_en),
    .sck   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sck_en  = 1'b0;
`ifdef SPI_PKT_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (done_s) begin
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(CLK_DIV - 1);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) state_d = ST_XFER;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      ST_XFER: begin
        sck_en = 1'b1;
        // bit_cnt has wrapped to 0 only after the 128th rising edge
        if (sck_fall && bit_cnt == 7'd0) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_ACK;
        cnt_d   = CNT_W'(LOAD_CYCLES - 1);
      end
      ST_ACK: begin
        if (cnt == '0) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_W'(TIMEOUT - 1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (!done_s) begin
          state_d = ST_IDLE;
        end
`ifdef SPI_PKT_TIMEOUT_EN
        else if (cnt == '0) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      sr      <= '0;
    end else if (state == ST_SETUP) begin
      bit_cnt <= '0;
    end else if (state == ST_XFER && sck_rise) begin
      sr      <= {sr[PACKET_BITS-2:0], sdi};
      bit_cnt <= bit_cnt + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load       <= 1'b0;
      pkt_valid  <= 1'b0;
      hdr_err    <= 1'b0;
      quat_w     <= '0;
      quat_x     <= '0;
      quat_y     <= '0;
      quat_z     <= '0;
      gyro_x     <= '0;
      gyro_y     <= '0;
      gyro_z     <= '0;
      quat_valid <= 1'b0;
      gyro_valid <= 1'b0;
    end else begin
      load      <= (state_d == ST_ACK);
      pkt_valid <= 1'b0;
      hdr_err   <= 1'b0;
      if (state == ST_DECODE) begin
        if (pkt_byte(sr, OFF_HDR) == HEADER_BYTE) begin
          quat_w    <= pkt_field16(sr, OFF_QW);
          quat_x    <= pkt_field16(sr, OFF_QX);
          quat_y    <= pkt_field16(sr, OFF_QY);
          quat_z    <= pkt_field16(sr, OFF_QZ);
          gyro_x    <= pkt_field16(sr, OFF_GX);
          gyro_y    <= pkt_field16(sr, OFF_GY);
          gyro_z    <= pkt_field16(sr, OFF_GZ);
          // flags byte is the last one shifted in, so it sits at the LSBs
          quat_valid <= sr[0];
          gyro_valid <= sr[1];
          pkt_valid  <= 1'b1;
        end else begin
          hdr_err <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_PKT_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timeout_err <= 1'b0;
    else       timeout_err <= tmo_d;
  end
`else
  assign timeout_err = 1'b0;
`endif

  assign busy = (state != ST_IDLE);
  assign sdo  = 1'b0;

endmodule

// File: tb/tb_spi_packet_master.sv
// Bench for spi_packet_master: a byte-array SPI slave feeds packets and a
// packet-level model predicts the field outputs.
module tb_spi_packet_master;
  import spi_pkt_pkg::*;

  localparam int CLK_DIV     = 4;
  localparam int LOAD_CYCLES = 8;
  localparam int TIMEOUT     = 100;

  logic clk = 1'b0;
  logic reset, done, sdi, load, sck, sdo;
  logic [15:0] quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z;
  logic quat_valid, gyro_valid, pkt_valid, hdr_err, timeout_err, busy;

  always #5 clk = ~clk;

  spi_packet_master #(.CLK_DIV(CLK_DIV), .LOAD_CYCLES(LOAD_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .done(done), .load(load), .sck(sck), .sdo(sdo), .sdi(sdi),
    .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .quat_valid(quat_valid), .gyro_valid(gyro_valid), .pkt_valid(pkt_valid),
    .hdr_err(hdr_err), .timeout_err(timeout_err), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   slv_bytes [PACKET_BYTES];
  int           slv_idx;
  logic         slv_reload = 1'b0;
  logic [113:0] exp_vec = '0;
  logic [113:0] got_vec;
  logic [127:0] good_pkt;

  assign got_vec = {quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z, gyro_valid, quat_valid};

  int r_busy_rise, r_rises, r_last_fall, r_pv_cnt, r_pv_cyc, r_he_cnt, r_load_first, r_load_len;
  bit r_timeout;

  function automatic logic slave_bit(input int idx);
    logic [7:0] b;
    if (idx >= PACKET_BITS) return 1'b0;
    b = slv_bytes[idx / 8];
    return b[7 - (idx % 8)];
  endfunction

  // Mode-0 slave: next bit after each falling sck edge; rewinds on load, reset or a new packet.
  always @(negedge sck or posedge load or posedge reset or posedge slv_reload) begin
    if (load || reset || slv_reload) slv_idx = 0;
    else                             slv_idx = slv_idx + 1;
    sdi = slave_bit(slv_idx);
  end

  function automatic void model_apply();
    sensor_pkt_t p;
    if (slv_bytes[0] == HEADER_BYTE) begin
      p = {slv_bytes[1], slv_bytes[2], slv_bytes[3], slv_bytes[4], slv_bytes[5],
           slv_bytes[6], slv_bytes[7], slv_bytes[8], slv_bytes[9], slv_bytes[10],
           slv_bytes[11], slv_bytes[12], slv_bytes[13], slv_bytes[14], slv_bytes[15]};
      exp_vec = {p.w, p.x, p.y, p.z, p.gx, p.gy, p.gz, p.flags[1], p.flags[0]};
    end
  endfunction

  task automatic set_packet(input logic [127:0] p);
    for (int i = 0; i < PACKET_BYTES; i++) slv_bytes[i] = p[127 - 8*i -: 8];
  endtask

  function automatic logic [127:0] rand_packet(input logic [7:0] hdr);
    logic [127:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    p[127:120] = hdr;
    return p;
  endfunction

  task automatic run_xfer(input bit toggle_ack);
    int cyc;
    bit fin;
    logic p_sck, p_busy, p_load;
    r_busy_rise = -1; r_rises = 0; r_last_fall = -1; r_pv_cnt = 0; r_pv_cyc = -1;
    r_he_cnt = 0; r_load_first = -1; r_load_len = 0;
    slv_reload = 1'b1; #1; slv_reload = 1'b0;
    done = 1'b1;
    p_sck = sck; p_busy = busy; p_load = load; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (busy && !p_busy && r_busy_rise < 0) r_busy_rise = cyc;
      if (sck && !p_sck) r_rises++;
      if (!sck && p_sck) r_last_fall = cyc;
      if (pkt_valid) begin r_pv_cnt++; r_pv_cyc = cyc; end
      if (hdr_err) r_he_cnt++;
      if (load) begin
        if (r_load_first < 0) r_load_first = cyc;
        r_load_len++;
      end
      if (!load && p_load) fin = 1'b1;
      if (toggle_ack && r_load_first >= 0) begin
        if (cyc == r_load_first)     done = 1'b0;
        if (cyc == r_load_first + 3) done = 1'b1;
      end
      p_sck = sck; p_busy = busy; p_load = load;
    end
    r_timeout = !fin;
  endtask

  task automatic drop_done(input int dly, output int lat);
    repeat (dly) @(negedge clk);
    done = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sck, load, busy, pkt_valid, hdr_err, timeout_err, sdo} !== 7'b0)
      $display("FAIL reset_ctl: got %b required 0000000", {sck, load, busy, pkt_valid, hdr_err, timeout_err, sdo});
    else n_pass++;
    n_checks++;
    if (got_vec !== '0) $display("FAIL reset_fields: got %h required 0", got_vec);
    else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_no_done: busy %b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_good_packet();
    int lat;
    set_packet(good_pkt);
    run_xfer(1'b0);
    model_apply();
    n_checks++;
    if (r_timeout) $display("FAIL good_xfer_budget: transfer did not finish");
    else n_pass++;
    n_checks++;
    if (r_pv_cnt != 1 || r_he_cnt != 0) $display("FAIL good_pulses: pkt_valid %0d hdr_err %0d required 1 0", r_pv_cnt, r_he_cnt);
    else n_pass++;
    n_checks++;
    if (r_rises != 128) $display("FAIL good_sck_rises: got %0d required 128", r_rises);
    else n_pass++;
    n_checks++;
    if (r_last_fall - r_busy_rise != CLK_DIV + 256*CLK_DIV)
      $display("FAIL good_setup_to_decode: got %0d required %0d", r_last_fall - r_busy_rise, CLK_DIV + 256*CLK_DIV);
    else n_pass++;
    n_checks++;
    if (r_pv_cyc != r_last_fall + 1 || r_load_first != r_pv_cyc)
      $display("FAIL good_pv_load_timing: pv %0d load %0d last_fall %0d", r_pv_cyc, r_load_first, r_last_fall);
    else n_pass++;
    n_checks++;
    if (r_load_len != LOAD_CYCLES) $display("FAIL good_load_len: got %0d required %0d", r_load_len, LOAD_CYCLES);
    else n_pass++;
    n_checks++;
    if ({quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z} !==
        {16'sd16384, 16'sd16, -16'sd16, 16'sd1, 16'sd100, -16'sd100, 16'h8000})
      $display("FAIL good_fields_const: got %h %h %h %h %h %h %h", quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z);
    else n_pass++;
    n_checks++;
    if ({quat_valid, gyro_valid} !== 2'b11) $display("FAIL good_flags: got %b required 11", {quat_valid, gyro_valid});
    else n_pass++;
    n_checks++;
    if (got_vec !== exp_vec) $display("FAIL good_fields_model: got %h required %h", got_vec, exp_vec);
    else n_pass++;
    drop_done(10, lat);
    n_checks++;
    if (lat != 3) $display("FAIL good_busy_fall: latency %0d required 3", lat);
    else n_pass++;
  endtask

  task automatic test_bad_header();
    logic [127:0] p;
    int lat;
    p = good_pkt;
    p[127:120] = 8'h55;
    p[7:0] = 8'h00;
    set_packet(p);
    run_xfer(1'b0);
    model_apply();
    n_checks++;
    if (r_timeout || r_pv_cnt != 0 || r_he_cnt != 1)
      $display("FAIL bad_hdr_pulses: pkt_valid %0d hdr_err %0d budget %0d", r_pv_cnt, r_he_cnt, r_timeout);
    else n_pass++;
    n_checks++;
    if (got_vec !== exp_vec) $display("FAIL bad_hdr_hold: got %h required %h", got_vec, exp_vec);
    else n_pass++;
    n_checks++;
    if (r_load_len != LOAD_CYCLES) $display("FAIL bad_hdr_load: got %0d required %0d", r_load_len, LOAD_CYCLES);
    else n_pass++;
    drop_done(10, lat);
    n_checks++;
    if (lat != 3) $display("FAIL bad_hdr_busy_fall: latency %0d required 3", lat);
    else n_pass++;
  endtask

  task automatic test_flags();
    logic [127:0] p;
    int lat;
    p = rand_packet(HEADER_BYTE);
    p[7:0] = 8'h01;
    set_packet(p);
    run_xfer(1'b0);
    model_apply();
    n_checks++;
    if (r_timeout || r_pv_cnt != 1) $display("FAIL flags_pv: got %0d required 1", r_pv_cnt);
    else n_pass++;
    n_checks++;
    if ({quat_valid, gyro_valid} !== 2'b10) $display("FAIL flags_bits: got %b required 10", {quat_valid, gyro_valid});
    else n_pass++;
    n_checks++;
    if (got_vec !== exp_vec) $display("FAIL flags_fields: got %h required %h", got_vec, exp_vec);
    else n_pass++;
    drop_done(10, lat);
  endtask

  task automatic test_random_packets();
    logic [127:0] p;
    logic [7:0] hb;
    bit ok;
    int lat;
    for (int k = 0; k < 5; k++) begin
      hb = 8'($urandom_range(0, 255));
      if (hb == HEADER_BYTE) hb = 8'h00;
      ok = (k != 2);
      p = rand_packet(ok ? HEADER_BYTE : hb);
      set_packet(p);
      run_xfer(1'b0);
      model_apply();
      n_checks++;
      if (r_timeout || r_pv_cnt != int'(ok) || r_he_cnt != int'(!ok))
        $display("FAIL rand_pulses_%0d: pkt_valid %0d hdr_err %0d", k, r_pv_cnt, r_he_cnt);
      else n_pass++;
      n_checks++;
      if (got_vec !== exp_vec) $display("FAIL rand_fields_%0d: got %h required %h", k, got_vec, exp_vec);
      else n_pass++;
      n_checks++;
      if (r_rises != 128) $display("FAIL rand_rises_%0d: got %0d required 128", k, r_rises);
      else n_pass++;
      drop_done(int'($urandom_range(1, 20)), lat);
      n_checks++;
      if (lat != 3) $display("FAIL rand_busy_fall_%0d: latency %0d required 3", k, lat);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int rises, cyc, lat;
    logic p_sck;
    set_packet(rand_packet(HEADER_BYTE));
    slv_reload = 1'b1; #1; slv_reload = 1'b0;
    done = 1'b1;
    rises = 0; cyc = 0; p_sck = sck;
    while (rises < 60 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (sck && !p_sck) rises++;
      p_sck = sck;
    end
    reset = 1'b1;
    #1;
    exp_vec = '0;
    n_checks++;
    if (rises != 60 || {sck, busy, load, pkt_valid} !== 4'b0)
      $display("FAIL rst_mid_ctl: rises %0d sck %b busy %b load %b", rises, sck, busy, load);
    else n_pass++;
    n_checks++;
    if (got_vec !== '0) $display("FAIL rst_mid_fields: got %h required 0", got_vec);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_xfer(1'b0);
    model_apply();
    n_checks++;
    if (r_timeout || r_pv_cnt != 1 || r_rises != 128)
      $display("FAIL rst_mid_rerun: pkt_valid %0d rises %0d", r_pv_cnt, r_rises);
    else n_pass++;
    n_checks++;
    if (got_vec !== exp_vec) $display("FAIL rst_mid_fields_after: got %h required %h", got_vec, exp_vec);
    else n_pass++;
    drop_done(5, lat);
  endtask

  task automatic test_done_in_ack();
    int lat, extra;
    set_packet(rand_packet(HEADER_BYTE));
    run_xfer(1'b1);
    model_apply();
    n_checks++;
    if (r_timeout || r_pv_cnt != 1 || r_load_len != LOAD_CYCLES)
      $display("FAIL ack_toggle_xfer: pkt_valid %0d load_len %0d", r_pv_cnt, r_load_len);
    else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL ack_toggle_wait: busy %b required 1", busy);
    else n_pass++;
    drop_done(0, lat);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || pkt_valid) extra++;
    end
    n_checks++;
    if (lat != 3 || extra != 0) $display("FAIL ack_toggle_extra: latency %0d extra %0d required 3 0", lat, extra);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int lat;
`ifndef SPI_PKT_TIMEOUT_EN
    int bad;
`endif
    set_packet(rand_packet(HEADER_BYTE));
    run_xfer(1'b0);
    model_apply();
`ifdef SPI_PKT_TIMEOUT_EN
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (timeout_err) begin lat = i; break; end
    end
    n_checks++;
    if (lat != TIMEOUT) $display("FAIL timeout_latency: got %0d required %0d", lat, TIMEOUT);
    else n_pass++;
    run_xfer(1'b0);
    n_checks++;
    if (r_timeout || r_pv_cnt != 1 || got_vec !== exp_vec)
      $display("FAIL timeout_reread: pkt_valid %0d got %h required %h", r_pv_cnt, got_vec, exp_vec);
    else n_pass++;
`else
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (!busy || timeout_err) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL no_timeout_hold: %0d cycles idle or timeout_err, required 0", bad);
    else n_pass++;
`endif
    drop_done(3, lat);
    n_checks++;
    if (lat != 3) $display("FAIL timeout_busy_fall: latency %0d required 3", lat);
    else n_pass++;
  endtask

  initial begin
    good_pkt = 128'hAA40_0000_10FF_F000_0100_64FF_9C80_0003;
    test_reset();
    test_good_packet();
    test_bad_header();
    test_flags();
    test_random_packets();
    test_reset_mid();
    test_done_in_ack();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
